jt12_din: RTL and testbench

CPU write-side interface for the JT12 FM core; it is the counterpart of `jt12_dout`, which handles the read side of the same four-address register bus. It detects host write strobes and keeps the shared register address latch and bank bit. Each data write is turned into a single-cycle register-write pulse toward the core, aligned to the chip clock enable. It generates the `busy` status bit that the read path reports back to the host.

---
 rtl/jt12_din_if.sv | 15 +
 rtl/jt12_din.sv | 150 +++++++++++++++
 tb/tb_jt12_din.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jt12_din_if.sv
// jt12_din_if: host write-side bus of the JT12 register interface.
//   cs_n  chip select, active-low
//   wr_n  write strobe, active-low
//   addr  [0] 0 = address port / 1 = data port, [1] bank
//   din   write data
// master: host side (drives the bus); slave: jt12_din (samples the bus).
interface jt12_din_if;
  logic       cs_n;
  logic       wr_n;
  logic [1:0] addr;
  logic [7:0] din;

  modport master (output cs_n, wr_n, addr, din);
  modport slave  (input  cs_n, wr_n, addr, din);
endinterface

// File: rtl/jt12_din.sv
// jt12_din: CPU write side of the JT12 FM core.
// Detects host write strobes, keeps the address latch and bank, turns each
// data write into a one-clk reg_wr pulse aligned to cen, and generates busy.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cen              chip clock enable
//   host             jt12_din_if.slave host bus (cs_n, wr_n, addr, din)
//   reg_addr/part/data  issued register write (held until next issue)
//   reg_wr           one-clk write pulse to the core
//   busy             busy status for the read mux
//   overrun          sticky overwrite flag, only with JT12_DIN_OVERRUN_EN
// Optional feature macro: JT12_DIN_OVERRUN_EN
module jt12_din #(
  parameter int unsigned BUSY_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  jt12_din_if.slave       host,
  output logic [7:0]      reg_addr,
  output logic            reg_part,
  output logic [7:0]      reg_data,
  output logic            reg_wr,
  output logic            busy
`ifdef JT12_DIN_OVERRUN_EN
  ,
  output logic            overrun
`endif
);

  localparam logic [7:0] CNT_LOAD = 8'(BUSY_CYCLES);

  logic       wr_l_q,     wr_l_d;
  logic [7:0] alatch_q,   alatch_d;
  logic       pend_q,     pend_d;
  logic [7:0] p_addr_q,   p_addr_d;
  logic       p_part_q,   p_part_d;
  logic [7:0] p_data_q,   p_data_d;
  logic [7:0] cnt_q,      cnt_d;
  logic       busy_q,     busy_d;
  logic       reg_wr_q,   reg_wr_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic       reg_part_q, reg_part_d;
  logic [7:0] reg_data_q, reg_data_d;

  logic wr_act;
  logic accept;
  logic acc_addr;
  logic acc_data;
  logic issue;

  assign wr_act   = !host.cs_n && !host.wr_n;
  assign accept   = wr_act && !wr_l_q;
  assign acc_addr = accept && !host.addr[0];
  assign acc_data = accept &&  host.addr[0];
  assign issue    = cen && pend_q;

  always_comb begin
    wr_l_d     = wr_act;
    alatch_d   = alatch_q;
    pend_d     = pend_q;
    p_addr_d   = p_addr_q;
    p_part_d   = p_part_q;
    p_data_d   = p_data_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    reg_wr_d   = issue;
    reg_addr_d = reg_addr_q;
    reg_part_d = reg_part_q;
    reg_data_d = reg_data_q;

    if (acc_addr) alatch_d = host.din;

    // Issue reads the old pending registers, so a simultaneous new data
    // write lands in pending without disturbing the write being issued.
    if (issue) begin
      reg_addr_d = p_addr_q;
      reg_part_d = p_part_q;
      reg_data_d = p_data_q;
      pend_d     = 1'b0;
    end

    if (acc_data) begin
      p_addr_d = alatch_q;
      p_part_d = host.addr[1];
      p_data_d = host.din;
      pend_d   = 1'b1;
      cnt_d    = CNT_LOAD;
      busy_d   = 1'b1;
    end else if (cen && !pend_q && cnt_q != '0) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_l_q     <= 1'b0;
      alatch_q   <= '0;
      pend_q     <= 1'b0;
      p_addr_q   <= '0;
      p_part_q   <= 1'b0;
      p_data_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_part_q <= 1'b0;
      reg_data_q <= '0;
    end else begin
      wr_l_q     <= wr_l_d;
      alatch_q   <= alatch_d;
      pend_q     <= pend_d;
      p_addr_q   <= p_addr_d;
      p_part_q   <= p_part_d;
      p_data_q   <= p_data_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      reg_wr_q   <= reg_wr_d;
      reg_addr_q <= reg_addr_d;
      reg_part_q <= reg_part_d;
      reg_data_q <= reg_data_d;
    end
  end

  assign reg_addr = reg_addr_q;
  assign reg_part = reg_part_q;
  assign reg_data = reg_data_q;
  assign reg_wr   = reg_wr_q;
  assign busy     = busy_q;

`ifdef JT12_DIN_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Only a write that is really lost counts; a pending write issuing on
  // the same cycle as the new acceptance is not overwritten.
  always_comb begin
    overrun_d = overrun_q;
    if (acc_data && pend_q && !issue) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_jt12_din.sv
// tb_jt12_din: scoreboard bench for jt12_din. Expected register writes are
// queued when data writes are issued; a negedge monitor pops and compares
// on every reg_wr pulse.
module tb_jt12_din;

  typedef struct packed {
    logic [7:0] a;
    logic       p;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b1;
  logic       cen_div = 1'b0;
  int         div_cnt = 0;
  logic [7:0] reg_addr;
  logic       reg_part;
  logic [7:0] reg_data;
  logic       reg_wr;
  logic       busy;
`ifdef JT12_DIN_OVERRUN_EN
  logic       overrun;
`endif

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  logic prev_wr = 1'b0;
  wr_t exp_q[$];

  jt12_din_if bus ();

  jt12_din #(.BUSY_CYCLES(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .host     (bus.slave),
    .reg_addr (reg_addr),
    .reg_part (reg_part),
    .reg_data (reg_data),
    .reg_wr   (reg_wr),
    .busy     (busy)
`ifdef JT12_DIN_OVERRUN_EN
    ,
    .overrun  (overrun)
`endif
  );

  always #5 clk = ~clk;

  // cen every 6th clk when cen_div is set
  always @(posedge clk) begin
    #1;
    if (cen_div) begin
      div_cnt = (div_cnt == 5) ? 0 : div_cnt + 1;
      cen = (div_cnt == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && reg_wr) begin
      wr_t e;
      pulses++;
      chk("reg_wr_not_consecutive", {31'd0, prev_wr}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_reg_wr", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("reg_addr", {24'd0, reg_addr}, {24'd0, e.a});
        chk("reg_part", {31'd0, reg_part}, {31'd0, e.p});
        chk("reg_data", {24'd0, reg_data}, {24'd0, e.d});
      end
    end
    prev_wr = reg_wr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_drive(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.addr = a; bus.din = d;
  endtask

  task automatic host_release();
    @(posedge clk); #1;
    bus.cs_n = 1'b1; bus.wr_n = 1'b1;
  endtask

  // Wait for reg_wr; latency in negedges since the strobe was driven and
  // cen ticks seen after the acceptance edge. Busy must be up meanwhile.
  task automatic wait_wr(input string name, input int lim, input int exp_lat, input int exp_ticks);
    int lat = 0;
    int ticks = 0;
    logic busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat > 1 && !reg_wr && !busy) busy_ok = 1'b0;
      if (lat > 1 && !reg_wr && cen) ticks++;
    end while (!reg_wr && lat < lim);
    chk({name, "_reg_wr_seen"}, {31'd0, reg_wr}, 32'd1);
    chk({name, "_busy_while_pending"}, {31'd0, busy_ok}, 32'd1);
    if (exp_lat >= 0) chk({name, "_latency"}, lat, exp_lat);
    if (exp_ticks >= 0) chk({name, "_cen_to_issue"}, ticks, exp_ticks);
  endtask

  // Called on the negedge where reg_wr is sampled high.
  task automatic measure_busy(input string name, input int exp_n, input int exp_ticks);
    int n = 0;
    int ticks = 0;
    while (busy && n < 2000) begin
      n++;
      if (cen) ticks++;
      @(negedge clk);
    end
    if (exp_n >= 0) chk({name, "_busy_cycles"}, n, exp_n);
    chk({name, "_busy_cen_ticks"}, ticks, exp_ticks);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drops", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int p0;
    bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.addr = 2'b00; bus.din = 8'h00;
    tick(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
    chk("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
    chk("rst_reg_part", {31'd0, reg_part}, 32'd0);
    chk("rst_reg_data", {24'd0, reg_data}, 32'd0);
`ifdef JT12_DIN_OVERRUN_EN
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
`endif

    // Basic write, cen tied high
    host_drive(2'b00, 8'h28);
    host_release();
    tick(2);
    chk("addr_write_no_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back('{a: 8'h28, p: 1'b0, d: 8'hF0});
    host_drive(2'b01, 8'hF0);
    wait_wr("basic", 10, 3, 1);
    measure_busy("basic", 32, 32);
    host_release();
    tick(2);

    // Bank and address latch, cen every 6th clk
    cen_div = 1'b1;
    host_drive(2'b10, 8'h30);
    host_release();
    tick(8);
    exp_q.push_back('{a: 8'h30, p: 1'b1, d: 8'h55});
    host_drive(2'b11, 8'h55);
    wait_wr("bank", 20, -1, 1);
    measure_busy("bank", -1, 32);
    host_release();
    cen_div = 1'b0;
    tick(1);
    cen = 1'b1;
    tick(2);

    // Long strobe: single pulse for a 20-cycle low strobe
    p0 = pulses;
    exp_q.push_back('{a: 8'h30, p: 1'b0, d: 8'hA5});
    host_drive(2'b01, 8'hA5);
    tick(20);
    host_release();
    wait_idle();
    chk("long_strobe_pulses", pulses - p0, 1);

    // Overwrite with cen low
    cen = 1'b0;
    p0 = pulses;
    host_drive(2'b01, 8'h11);
    host_release();
    host_drive(2'b01, 8'h22);
    host_release();
    tick(3);
    chk("overwrite_no_early_pulse", pulses - p0, 0);
`ifdef JT12_DIN_OVERRUN_EN
    chk("overrun_set", {31'd0, overrun}, 32'd1);
`endif
    exp_q.push_back('{a: 8'h30, p: 1'b0, d: 8'h22});
    cen = 1'b1;
    wait_wr("overwrite", 10, 2, -1);
    measure_busy("overwrite", 32, 32);
    tick(5);
    chk("overwrite_pulses", pulses - p0, 1);

    // Reset with a pending write
    cen = 1'b0;
    host_drive(2'b01, 8'h77);
    host_release();
    tick(2);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_reg_data", {24'd0, reg_data}, 32'd0);
`ifdef JT12_DIN_OVERRUN_EN
    chk("async_reset_overrun", {31'd0, overrun}, 32'd0);
`endif
    p0 = pulses;
    tick(3);
    cen = 1'b1;
    rst_n = 1'b1;
    tick(40);
    chk("no_pulse_after_reset", pulses - p0, 0);
    chk("busy_after_reset", {31'd0, busy}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
